// File: rtl/mixer_pkg.sv
// -----------------------------------------------------------------------------
// mixer_pkg
// Shared types and helpers for the voice mixer.
//   mixer_state_t : frame sequencer states
//   sat_signed()  : clamp a signed value to a given two's-complement width
// FIXED_POINT is the oscillator fraction width. Normally it comes from
// constants.svh. The guarded fallback below lets the package compile on its own.
// -----------------------------------------------------------------------------
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    SCALE   = 2'd2,
    PRESENT = 2'd3
  } mixer_state_t;

  // Clamping is done in this fixed container width. Callers sign-extend into it.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int                      width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi)
      return hi;
    else if (value < lo)
      return lo;
    else
      return value;
  endfunction

endpackage

// File: rtl/mixer_saturate.sv
// -----------------------------------------------------------------------------
// mixer_saturate
// Combinational clamp of a wide signed value to OUT_W bits.
//   value     in  IN_W   signed value to clamp (IN_W <= 64)
//   sat_value out OUT_W  clamped value
//   clip      out 1      high when clamping changed the value
// -----------------------------------------------------------------------------
module mixer_saturate
  import mixer_pkg::*;
#(
  parameter int IN_W  = 45,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  value,
  output logic signed [OUT_W-1:0] sat_value,
  output logic                    clip
);

  logic signed [SAT_W-1:0] ext;
  logic signed [SAT_W-1:0] clamped;

  always_comb begin
    ext       = SAT_W'(value);
    clamped   = sat_signed(ext, OUT_W);
    sat_value = clamped[OUT_W-1:0];
    clip      = (clamped != ext);
  end

endmodule

// File: rtl/voice_mixer.sv
// -----------------------------------------------------------------------------
// voice_mixer
// Sums N_VOICES signed oscillator samples once per sample period. A single
// adder handles one voice per clock. The sum is scaled by the master volume,
// the fixed-point fraction is dropped, and the result is saturated to
// OUT_WIDTH. The result is then offered on a valid/ready handshake.
//
// Ports
//   clk          in   system clock
//   rstn         in   async active-low reset
//   sample_tick  in   1-cycle pulse that starts a mix frame
//   voices_in    in   N_VOICES x (WIDTH+FIXED_POINT) signed samples
//   voice_en     in   per-voice enable
//   master_vol   in   master gain, gain = master_vol / 2**VOL_WIDTH
//   out_sample   out  signed mixed sample
//   out_valid    out  out_sample valid
//   out_ready    in   consumer ready
//   busy         out  frame in progress (state != IDLE)
//   clip         out  1-cycle pulse when the sample was saturated
//   overrun      out  sticky: sample_tick seen while busy
//   peak_level   out  (MIXER_PEAK_METER_EN) peak |sample| since clear
//   peak_clear   in   (MIXER_PEAK_METER_EN) clear peak_level
//
// Optional feature macro: MIXER_PEAK_METER_EN
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for sample_tick; snapshot taken on the tick
// ACCUM   | adding one snapshotted voice per cycle into acc
// SCALE   | volume multiply, fraction drop, saturate, load out_sample
// PRESENT | out_valid held until the consumer accepts
// -----------------------------------------------------------------------------
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int N_VOICES  = 16,
  parameter int WIDTH     = 24,
  parameter int OUT_WIDTH = 24,
  parameter int VOL_WIDTH = 8
) (
  input  logic                                           clk,
  input  logic                                           rstn,
  input  logic                                           sample_tick,
  input  logic [N_VOICES-1:0][WIDTH+`FIXED_POINT-1:0]    voices_in,
  input  logic [N_VOICES-1:0]                            voice_en,
  input  logic [VOL_WIDTH-1:0]                           master_vol,
  output logic signed [OUT_WIDTH-1:0]                    out_sample,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           busy,
  output logic                                           clip,
  output logic                                           overrun
`ifdef MIXER_PEAK_METER_EN
  ,
  output logic [OUT_WIDTH-2:0]                           peak_level,
  input  logic                                           peak_clear
`endif
);

  localparam int IN_W   = WIDTH + `FIXED_POINT;
  localparam int IDX_W  = $clog2(N_VOICES);
  // log2(N) guard bits are enough to make the sum of N voices overflow-free.
  localparam int ACC_W  = IN_W + IDX_W;
  // The extra bit holds the unsigned volume as a non-negative signed operand.
  localparam int PROD_W = ACC_W + VOL_WIDTH + 1;
  localparam int SHIFT  = VOL_WIDTH + `FIXED_POINT;

  mixer_state_t                       state;
  mixer_state_t                       state_nxt;

  logic [N_VOICES-1:0][IN_W-1:0]      voices_q;
  logic [N_VOICES-1:0]                voice_en_q;
  logic [VOL_WIDTH-1:0]               vol_q;
  logic [IDX_W-1:0]                   idx;
  logic signed [ACC_W-1:0]            acc;

  logic signed [ACC_W-1:0]            addend;
  logic signed [PROD_W-1:0]           product;
  logic signed [PROD_W-1:0]           scaled;
  logic signed [OUT_WIDTH-1:0]        sat_value;
  logic                               sat_clip;
  logic                               last_voice;

  assign busy       = (state != IDLE);
  assign last_voice = (idx == IDX_W'(N_VOICES - 1));

  always_comb begin
    addend = '0;
    if (voice_en_q[idx])
      addend = ACC_W'($signed(voices_q[idx]));
  end

  // Signed product, then an arithmetic shift. The shift rounds toward minus infinity.
  assign product = PROD_W'(acc) * PROD_W'($signed({1'b0, vol_q}));
  assign scaled  = product >>> SHIFT;

  mixer_saturate #(
    .IN_W  (PROD_W),
    .OUT_W (OUT_WIDTH)
  ) u_saturate (
    .value     (scaled),
    .sat_value (sat_value),
    .clip      (sat_clip)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = ACCUM;
      ACCUM:   if (last_voice)  state_nxt = SCALE;
      SCALE:                    state_nxt = PRESENT;
      PRESENT: if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      voices_q   <= '0;
      voice_en_q <= '0;
      vol_q      <= '0;
      idx        <= '0;
      acc        <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      clip       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      clip <= 1'b0;
      if (sample_tick && (state != IDLE))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            voices_q   <= voices_in;
            voice_en_q <= voice_en;
            vol_q      <= master_vol;
            idx        <= '0;
            acc        <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + addend;
          idx <= idx + IDX_W'(1);
        end
        SCALE: begin
          out_sample <= sat_value;
          out_valid  <= 1'b1;
          clip       <= sat_clip;
        end
        PRESENT: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MIXER_PEAK_METER_EN
  logic [OUT_WIDTH-1:0] neg_value;
  logic [OUT_WIDTH-2:0] magnitude;

  // The most negative sample has no positive twin in OUT_WIDTH-1 bits.
  // Its magnitude is pinned to full scale.
  always_comb begin
    neg_value = -sat_value;
    magnitude = sat_value[OUT_WIDTH-2:0];
    if (sat_value[OUT_WIDTH-1]) begin
      if (neg_value[OUT_WIDTH-1])
        magnitude = '1;
      else
        magnitude = neg_value[OUT_WIDTH-2:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      peak_level <= '0;
    else if (peak_clear)
      peak_level <= '0;
    else if ((state == SCALE) && (magnitude > peak_level))
      peak_level <= magnitude;
  end
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// -----------------------------------------------------------------------------
// tb_voice_mixer
// Directed bench for voice_mixer (N_VOICES=4, WIDTH=24, OUT_WIDTH=24,
// VOL_WIDTH=8). A frame-level reference model predicts the outputs from the
// snapshot taken at each accepted tick and the fixed tick-to-valid latency.
// A checker compares the DUT against the model on every falling edge.
// Directed tasks add literal expectations.
// Honours MIXER_PEAK_METER_EN.
// -----------------------------------------------------------------------------
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

module tb_voice_mixer;

  localparam int NV   = 4;
  localparam int FP   = `FIXED_POINT;
  localparam int IW   = 24 + FP;
  localparam longint OMAX = 64'sd8388607;
  localparam longint OMIN = -64'sd8388608;

  logic                     clk;
  logic                     rstn;
  logic                     sample_tick;
  logic [NV-1:0][IW-1:0]    voices_in;
  logic [NV-1:0]            voice_en;
  logic [7:0]               master_vol;
  logic signed [23:0]       out_sample;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     clip;
  logic                     overrun;
`ifdef MIXER_PEAK_METER_EN
  logic [22:0]              peak_level;
  logic                     peak_clear;
`endif

  int n_vec = 0;
  int n_err = 0;

  voice_mixer #(
    .N_VOICES  (NV),
    .WIDTH     (24),
    .OUT_WIDTH (24),
    .VOL_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sample_tick (sample_tick),
    .voices_in   (voices_in),
    .voice_en    (voice_en),
    .master_vol  (master_vol),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .clip        (clip),
    .overrun     (overrun)
`ifdef MIXER_PEAK_METER_EN
    ,
    .peak_level  (peak_level),
    .peak_clear  (peak_clear)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] vk(input longint k);
    return IW'(k <<< FP);
  endfunction

  function automatic logic [NV-1:0][IW-1:0] pack4(input longint a, input longint b,
                                                   input longint c, input longint d);
    logic [NV-1:0][IW-1:0] r;
    r[0] = vk(a);
    r[1] = vk(b);
    r[2] = vk(c);
    r[3] = vk(d);
    return r;
  endfunction

  // Reference computation: the plain integer formula, with floor via an arithmetic shift.
  task automatic model_mix(input logic [NV-1:0][IW-1:0] vin, input logic [NV-1:0] en,
                           input logic [7:0] vol, output longint res, output bit clipped);
    longint sum;
    longint p;
    sum = 0;
    for (int i = 0; i < NV; i++)
      if (en[i]) sum += longint'($signed(vin[i]));
    p = (sum * longint'({56'd0, vol})) >>> (8 + FP);
    clipped = 1'b0;
    res = p;
    if (p > OMAX) begin res = OMAX; clipped = 1'b1; end
    if (p < OMIN) begin res = OMIN; clipped = 1'b1; end
  endtask

  // ---------------- reference model + per-cycle checker ----------------
  int     m_age;     // -1 when idle, otherwise edges since the accepted tick
  bit     m_valid;
  longint m_sample;
  bit     m_clip;
  bit     m_over;
  longint m_res;
  bit     m_rclip;
  longint m_peak;

  always @(negedge clk) begin
    longint mag;
    if (!rstn) begin
      m_age = -1; m_valid = 0; m_sample = 0; m_clip = 0; m_over = 0;
      m_res = 0; m_rclip = 0; m_peak = 0;
    end
    chk("model_busy",    longint'(busy),      longint'(m_age >= 0));
    chk("model_valid",   longint'(out_valid), longint'(m_valid));
    chk("model_sample",  longint'(out_sample), m_sample);
    chk("model_clip",    longint'(clip),      longint'(m_clip));
    chk("model_overrun", longint'(overrun),   longint'(m_over));
`ifdef MIXER_PEAK_METER_EN
    chk("model_peak",    longint'(peak_level), m_peak);
`endif
    if (rstn) begin
      m_clip = 0;
      if (m_age < 0) begin
        if (sample_tick) begin
          model_mix(voices_in, voice_en, master_vol, m_res, m_rclip);
          m_age = 0;
        end
`ifdef MIXER_PEAK_METER_EN
        if (peak_clear) m_peak = 0;
`endif
      end else begin
        if (sample_tick) m_over = 1;
        if (m_valid) begin
          if (out_ready) begin
            m_valid = 0;
            m_age = -1;
          end
`ifdef MIXER_PEAK_METER_EN
          if (peak_clear) m_peak = 0;
`endif
        end else begin
          m_age++;
          if (m_age == NV + 1) begin
            m_valid  = 1;
            m_sample = m_res;
            m_clip   = m_rclip;
          end
`ifdef MIXER_PEAK_METER_EN
          mag = (m_res < 0) ? ((m_res == OMIN) ? OMAX : -m_res) : m_res;
          if (peak_clear) m_peak = 0;
          else if (m_age == NV + 1 && mag > m_peak) m_peak = mag;
`else
          mag = 0;
`endif
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string nm, input logic [NV-1:0][IW-1:0] v,
                           input logic [NV-1:0] en, input logic [7:0] vol,
                           input longint exp_s, input bit exp_c);
    int lat;
    voices_in   = v;
    voice_en    = en;
    master_vol  = vol;
    sample_tick = 1'b1;
    edge1();
    sample_tick = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      edge1();
      lat++;
      if (lat == 1) begin
        // Inputs change after the snapshot; the current frame must ignore this.
        voices_in  = ~voices_in;
        voice_en   = ~voice_en;
        master_vol = ~master_vol;
      end
    end
    chk({nm, "_latency"}, lat, NV + 1);
    chk({nm, "_sample"}, longint'(out_sample), exp_s);
    chk({nm, "_clip"}, longint'(clip), longint'(exp_c));
    edge1();
    edge1();
    chk({nm, "_done"}, longint'(out_valid), 0);
  endtask

  initial begin
    longint r;
    bit     c;
    int     hs;
    rstn        = 1'b0;
    sample_tick = 1'b0;
    voices_in   = '0;
    voice_en    = '0;
    master_vol  = '0;
    out_ready   = 1'b1;
`ifdef MIXER_PEAK_METER_EN
    peak_clear  = 1'b0;
`endif
    repeat (3) edge1();
    chk("rst_sample",  longint'(out_sample), 0);
    chk("rst_valid",   longint'(out_valid), 0);
    chk("rst_busy",    longint'(busy), 0);
    chk("rst_clip",    longint'(clip), 0);
    chk("rst_overrun", longint'(overrun), 0);
    rstn = 1'b1;
    edge1();

    // The model reproduces hand-computed results.
    model_mix(pack4(1000, 2000, -500, 0), 4'b1111, 8'd255, r, c);
    chk("pin_model_t1", r, 2490);
    model_mix(pack4(8388607, 8388607, 8388607, 8388607), 4'b1111, 8'd255, r, c);
    chk("pin_model_t2", r, 8388607);
    chk("pin_model_t2_clip", longint'(c), 1);

    run_frame("t1", pack4(1000, 2000, -500, 0), 4'b1111, 8'd255, 2490, 0);
    run_frame("t2_pos", pack4(8388607, 8388607, 8388607, 8388607), 4'b1111, 8'd255, 8388607, 1);
    run_frame("t2_neg", pack4(-8388608, -8388608, -8388608, -8388608), 4'b1111, 8'd255, -8388608, 1);
    run_frame("t3", pack4(10, 99, 20, 99), 4'b0101, 8'd255, 29, 0);
    run_frame("vol0", pack4(1000, 2000, -500, 0), 4'b1111, 8'd0, 0, 0);
    run_frame("alldis", pack4(1000, 2000, -500, 7), 4'b0000, 8'd255, 0, 0);
    run_frame("half", pack4(-3, 0, 0, 0), 4'b0001, 8'd128, -2, 0);

    // t4: backpressure, overrun, then a single handshake.
    out_ready   = 1'b0;
    voices_in   = pack4(1000, 2000, -500, 0);
    voice_en    = 4'b1111;
    master_vol  = 8'd255;
    sample_tick = 1'b1;
    edge1();
    sample_tick = 1'b0;
    for (int k = 0; k < NV + 1 + 20; k++) begin
      edge1();
      if (k == NV + 6) sample_tick = 1'b1;
      if (k == NV + 7) sample_tick = 1'b0;
    end
    chk("t4_hold_valid", longint'(out_valid), 1);
    chk("t4_hold_sample", longint'(out_sample), 2490);
    chk("t4_overrun", longint'(overrun), 1);
    chk("t4_busy", longint'(busy), 1);
    out_ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid && out_ready) hs++;
      edge1();
    end
    chk("t4_handshakes", hs, 1);
    chk("t4_idle", longint'(busy), 0);
    chk("t4_no_new_frame", longint'(out_valid), 0);

    // t5: reset during ACCUM clears everything immediately.
    voices_in   = pack4(5000, 5000, 5000, 5000);
    voice_en    = 4'b1111;
    master_vol  = 8'd255;
    sample_tick = 1'b1;
    edge1();
    sample_tick = 1'b0;
    edge1();
    rstn = 1'b0;
    #1;
    chk("t5_valid_now", longint'(out_valid), 0);
    chk("t5_busy_now", longint'(busy), 0);
    chk("t5_overrun_clr", longint'(overrun), 0);
    edge1();
    rstn = 1'b1;
    edge1();
    run_frame("t5_fresh", pack4(10, 99, 20, 99), 4'b0101, 8'd255, 29, 0);

`ifdef MIXER_PEAK_METER_EN
    peak_clear = 1'b1;
    edge1();
    peak_clear = 1'b0;
    chk("t6_clear0", longint'(peak_level), 0);
    run_frame("t6_a", pack4(101, 0, 0, 0), 4'b0001, 8'd255, 100, 0);
    run_frame("t6_b", pack4(-301, 0, 0, 0), 4'b0001, 8'd255, -300, 0);
    run_frame("t6_c", pack4(51, 0, 0, 0), 4'b0001, 8'd255, 50, 0);
    chk("t6_peak", longint'(peak_level), 300);
    run_frame("t6_min", pack4(-8388608, -8388608, -8388608, -8388608), 4'b1111, 8'd255, -8388608, 1);
    chk("t6_peak_min", longint'(peak_level), 8388607);
    peak_clear = 1'b1;
    edge1();
    peak_clear = 1'b0;
    chk("t6_clear", longint'(peak_level), 0);
`endif

    repeat (3) edge1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
